// File: rtl/itoh_tsuji_sequencer.sv
// GF(2^8) Itoh-Tsuji inversion sequencer: a^-1 = a^254 via chain 1-2-3-6-7.
// Drives the beta storage bank write/read selectors and owns the accumulator.
module itoh_tsuji_sequencer #(
    parameter logic [7:0] POLY = 8'h1B
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] a,
    output logic       busy,
    output logic       done,
    output logic [7:0] inv,
    output logic [1:0] sel_write,
    output logic [7:0] data_write,
    output logic [1:0] sel_read,
    input  logic [7:0] data_read
);

    typedef enum logic [1:0] {
        IDLE,
        SQR,
        MUL,
        FIN
    } state_t;

    state_t     state;
    logic [7:0] acc;
    logic [1:0] cnt;
    logic [1:0] s;
    logic [7:0] sq;
    logic [7:0] prod;
    logic       last_sq;

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h00;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) r = r ^ b;
            b = b[7] ? ({b[6:0], 1'b0} ^ POLY) : {b[6:0], 1'b0};
        end
        return r;
    endfunction

    assign sq      = gf_mul(acc, acc);
    assign prod    = gf_mul(acc, data_read);
    // step 2 (beta3 -> beta6) needs three squarings, every other step one
    assign last_sq = (s == 2'd2) ? (cnt == 2'd2) : (cnt == 2'd0);

    always_comb begin
        sel_write  = 2'b00;
        data_write = 8'h00;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_write  = 2'b10;
                        data_write = a;
                    end
                end
                MUL: begin
                    if (s == 2'd1) begin
                        sel_write  = 2'b01;
                        data_write = prod;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            acc      <= 8'h00;
            cnt      <= 2'd0;
            s        <= 2'd0;
            inv      <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            sel_read <= 2'b00;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= a;
                        busy     <= 1'b1;
                        s        <= 2'd0;
                        cnt      <= 2'd0;
                        sel_read <= 2'b00;
                        state    <= SQR;
                    end
                end
                SQR: begin
                    acc <= sq;
                    cnt <= cnt + 2'd1;
                    if (last_sq) state <= MUL;
                end
                MUL: begin
                    acc <= prod;
                    if (s == 2'd3) begin
                        sel_read <= 2'b00;
                        state    <= FIN;
                    end else begin
                        s        <= s + 2'd1;
                        cnt      <= 2'd0;
                        // step 2 multiplies by beta3, held in slot1
                        sel_read <= (s == 2'd1) ? 2'b01 : 2'b00;
                        state    <= SQR;
                    end
                end
                FIN: begin
                    inv   <= sq;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_itoh_tsuji_sequencer.sv
// Bench for itoh_tsuji_sequencer with a behavioural beta storage bank.
// Expected inverses come from a power model built on polynomial arithmetic.
module tb_itoh_tsuji_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] inv;
    logic [1:0] sel_write;
    logic [7:0] data_write;
    logic [1:0] sel_read;
    logic [7:0] data_read = 8'h00;

    logic [7:0] slot0 = 8'h00;
    logic [7:0] slot1 = 8'h00;

    int ntest = 0;
    int nfail = 0;

    itoh_tsuji_sequencer #(.POLY(8'h1B)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .inv       (inv),
        .sel_write (sel_write),
        .data_write(data_write),
        .sel_read  (sel_read),
        .data_read (data_read)
    );

    always #5 CLK = ~CLK;

    // storage bank: write on the edge, registered read one edge later
    always @(posedge CLK) begin
        if (sel_write == 2'b10) slot0 <= data_write;
        if (sel_write == 2'b01) slot1 <= data_write;
        data_read <= sel_read[0] ? slot1 : slot0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntest++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // full carry-less product, then reduce modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (y[i]) p = p ^ (16'(x) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_pow(input logic [7:0] x, input int e);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < e; i++) r = ref_mul(r, x);
        return r;
    endfunction

    // one operation; pulse_k>0 pulses a stray start before edge E<pulse_k>
    task automatic run_op(input logic [7:0] av, input int pulse_k, input bit hold);
        logic [7:0] exp;
        logic [1:0] exp_sr;
        exp = ref_pow(av, 254);
        @(negedge CLK);
        start = 1'b1;
        a = av;
        #1;
        check("busy_e0", busy, 0);
        check("sw_e0", sel_write, 2'b10);
        check("dw_e0", data_write, av);
        @(posedge CLK);
        #1;
        start = hold;
        a = 8'($urandom);
        for (int k = 1; k <= 11; k++) begin
            if (k == pulse_k) begin
                start = 1'b1;
                a = 8'h02;
            end
            #1;
            check("busy", busy, 1);
            check("done", done, 0);
            check("sw", sel_write, (k == 4) ? 2'b01 : 2'b00);
            if (k == 4) check("dw_beta3", data_write, ref_pow(av, 7));
            if (k == 1 || k == 3 || k == 5 || k == 6 || k == 7 || k == 9) begin
                exp_sr = (k >= 5 && k <= 7) ? 2'b01 : 2'b00;
                check("sel_read", sel_read, exp_sr);
            end
            @(posedge CLK);
            #1;
            start = hold;
        end
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("inv", inv, exp);
        if (av != 8'h00) check("a_x_inv", ref_mul(av, inv), 8'h01);
        else check("inv_zero", inv, 8'h00);
    endtask

    initial begin
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_inv", inv, 0);
        check("rst_sw", sel_write, 0);
        check("rst_sr", sel_read, 0);
        @(negedge CLK);
        RST = 1'b0;

        run_op(8'h53, 0, 1'b0);
        check("inv_53", inv, 8'hCA);
        run_op(8'h01, 0, 1'b0);
        check("inv_01", inv, 8'h01);
        run_op(8'h02, 0, 1'b0);
        check("inv_02", inv, 8'h8D);
        run_op(8'h00, 0, 1'b0);
        check("inv_00", inv, 8'h00);

        run_op(8'h53, 5, 1'b0);
        check("ignored_start", inv, 8'hCA);

        run_op(8'h53, 0, 1'b1);
        run_op(8'h53, 0, 1'b0);
        check("b2b", inv, 8'hCA);

        // abort mid-operation with an asynchronous reset
        @(negedge CLK);
        start = 1'b1;
        a = 8'h53;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_inv", inv, 0);
        check("abort_sr", sel_read, 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            check("no_done_after_abort", done, 0);
        end
        run_op(8'h02, 0, 1'b0);
        check("after_abort", inv, 8'h8D);

        for (int i = 0; i < 24; i++)
            run_op(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : 0,
                   1'($urandom_range(0, 1)));

        for (int v = 0; v < 256; v++) run_op(8'(v), 0, 1'b0);

        start = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/itoh_tsuji_sequencer.md
Name: itoh_tsuji_sequencer

Overview:
- Control and datapath stage directly upstream of the beta storage bank in the GF(2^8) Itoh-Tsuji inverter.
- Computes inv = a^-1 = a^254 using addition chain 1 -> 2 -> 3 -> 6 -> 7 on beta_k = a^(2^k - 1), followed by a final squaring.
- Writes intermediate betas into the storage bank and reads them back as multiplier operands, through the bank's separate write and read selectors.
- Field is GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1.

Parameters:
- POLY, 8'h1B, low 8 bits of the reduction polynomial (x^8 implied). Used by both the squarer and the multiplier.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only while busy=0.
- a  in  8  operand; sampled on the edge where start is accepted.
- busy  out  1  high from the accept edge until done is asserted.
- done  out  1  one-cycle pulse; inv is valid in that cycle.
- inv  out  8  result register; holds its value until the next result.
- sel_write  out  2  storage write select: 00 none, 10 slot0, 01 slot1. Code 11 is never driven.
- data_write  out  8  storage write data.
- sel_read  out  2  storage read select: 00 slot0, 01 slot1. The storage returns registered data one edge later.
- data_read  in  8  storage read data, used as the multiplier operand.

Behaviour:
- Reset (async): state=IDLE, acc=0, cnt=0, inv=0, busy=0, done=0, sel_write=00, data_write=0, sel_read=00.
- Datapath:
  - acc is an 8-bit register.
  - SQR step: acc <= acc^2 mod P.
  - MUL step: acc <= acc*data_read mod P.
  - Both operations are combinational and finish in one cycle.
  - All arithmetic is carry-less (XOR); no width growth is stored.
- States: IDLE, SQR, MUL, FIN, plus a 2-bit step index s (0..3) and a square counter cnt.
- IDLE:
  - sel_write=10 and data_write=a (combinational) while start=1.
  - On edge E0 with start=1: acc<=a (beta1 is stored in slot0), busy<=1, s<=0, cnt<=0, state->SQR.
- Step table (squares, operand slot):
  - s0: 1 square, slot0, gives beta2.
  - s1: 1 square, slot0, gives beta3.
  - s2: 3 squares, slot1, gives beta6.
  - s3: 1 square, slot0, gives beta7.
- SQR:
  - Square each edge; cnt increments.
  - sel_read = the step's slot for every SQR cycle, so data_read holds the operand on the MUL edge.
  - After the last square of the step, go to MUL.
- MUL:
  - acc <= acc*data_read.
  - In s1, drive sel_write=01 and data_write=product in the same cycle, so beta3 is stored to slot1.
  - s<3: s++, cnt<=0, state->SQR.
  - s=3: state->FIN.
- FIN: inv <= acc^2, done<=1, busy<=0, state->IDLE.
- Cycle schedule:
  - E1 SQR, E2 MUL (beta2).
  - E3 SQR, E4 MUL + store slot1 (beta3).
  - E5–E7 SQR, E8 MUL (beta6).
  - E9 SQR, E10 MUL (beta7).
  - E11 FIN.
  - done is high in the cycle after E11: fixed latency of 11 edges after accept.
- sel_write is 00 in every cycle not listed above. At most one write per cycle. A slot is never read on the same edge it is written.
- start while busy=1 is ignored; a is not resampled.
- start in the done cycle is accepted (busy=0); done drops on that edge.
- a=0 needs no special case and yields inv=0 (0^254=0).
- RST asserted mid-operation aborts the operation: all outputs return to reset values at once. No done pulse occurs. Storage contents are not relied on afterwards, because slot0 is rewritten on every accept.

Test Plan:
- Reset release, start a=8'h53 -> busy for 11 cycles, done pulse exactly 11 edges after accept, inv=8'hCA.
- a=8'h01 -> inv=8'h01; a=8'h02 -> inv=8'h8D; a=8'h00 -> inv=8'h00. Each run follows the same 11-edge latency.
- Storage port check on a=8'h53:
  - sel_write=10 with data=8'h53 on E0 only.
  - sel_write=01 with data=beta3=a^7 on E4 only.
  - sel_read=01 on E5–E7 and 00 in every other SQR cycle.
- Start pulsed again at E5 with a=8'h02 -> ignored; the result is still 8'hCA.
- Start held high through done -> the next operation is accepted in the done cycle. Back-to-back results 8'hCA, 8'hCA with no idle gap.
- RST pulsed at E6 -> busy=0, done=0, inv=0 immediately. A subsequent start a=8'h02 gives 8'h8D.
- Exhaustive sweep over all 256 inputs: a*inv=1 for every a!=0, and inv(0)=0.
